// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC mode encodings,
// exception cause codes, default reset/vector addresses and the FSM state type.
package pc_pkg;

  // Next-PC mode, driven by the controller on sel
  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BEQ  = 3'b001;
  localparam logic [2:0] SEL_BNE  = 3'b010;
  localparam logic [2:0] SEL_J    = 3'b011;
  localparam logic [2:0] SEL_JR   = 3'b100;
  localparam logic [2:0] SEL_ERET = 3'b101;

  // Cause codes reported on exc_code
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

  // Exception level; the encoding is exported directly as exl
  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StHandler = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the controller/datapath and pc_unit.
//   master: controller side, drives stall/sel/zero/imm/jr_addr/irq/irq_en
//           and observes pc/pc_plus4/epc/exl/exc_code/exc_taken.
//   slave : pc_unit side, the mirror image.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             stall;
  logic [2:0]       sel;
  logic             zero;
  logic [25:0]      imm;
  logic [WIDTH-1:0] jr_addr;
  logic             irq;
  logic             irq_en;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             exl;
  logic [4:0]       exc_code;
  logic             exc_taken;

  modport master (
    output stall, sel, zero, imm, jr_addr, irq, irq_en,
    input  pc, pc_plus4, epc, exl, exc_code, exc_taken
  );

  modport slave (
    input  stall, sel, zero, imm, jr_addr, irq, irq_en,
    output pc, pc_plus4, epc, exl, exc_code, exc_taken
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC target selection.
//   sel           next-PC mode (SEQ/BEQ/BNE/J/JR/ERET, 110/111 behave as SEQ)
//   zero          ALU zero flag for branches
//   imm           [15:0] branch offset, [25:0] jump index
//   pc_plus4      current pc + 4
//   jr_addr       register-jump target
//   epc           exception return address
//   npc           selected target
//   jr_misaligned JR selected with a target that is not word aligned
module npc_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic             zero,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] npc,
  output logic             jr_misaligned
);

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;

  // Word offset: sign-extend imm[15:0] and scale by 4
  assign br_target = pc_plus4 + {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  // Jump keeps the upper region bits of the delay-free pc+4
  assign j_target  = {pc_plus4[WIDTH-1:28], imm[25:0], 2'b00};

  assign jr_misaligned = (sel == SEL_JR) && (jr_addr[1:0] != 2'b00);

  always_comb begin
    npc = pc_plus4;
    unique case (sel)
      SEL_BEQ:  npc = zero ? br_target : pc_plus4;
      SEL_BNE:  npc = zero ? pc_plus4 : br_target;
      SEL_J:    npc = j_target;
      SEL_JR:   npc = jr_addr;
      SEL_ERET: npc = epc;
      default:  npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-fetch selection, exception entry
// (interrupt, misaligned JR target) and exception return.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pc_unit_if slave: stall/sel/zero/imm/jr_addr/irq/irq_en in,
//        pc/pc_plus4/epc/exl/exc_code/exc_taken out
// WIDTH must be at least 32.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [4:0]       code_q, code_d;
  logic             taken_q, taken_d;
  pc_state_e        state_q, state_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] npc;
  logic             jr_misaligned;
  logic             exc_adel;
  logic             exc_int;

  assign pc_plus4 = pc_q + WIDTH'(4);

  npc_calc #(
    .WIDTH (WIDTH)
  ) u_npc_calc (
    .sel           (bus.sel),
    .zero          (bus.zero),
    .imm           (bus.imm),
    .pc_plus4      (pc_plus4),
    .jr_addr       (bus.jr_addr),
    .epc           (epc_q),
    .npc           (npc),
    .jr_misaligned (jr_misaligned)
  );

  // AdEL outranks the interrupt; interrupts are masked inside the handler
  assign exc_adel = !bus.stall && jr_misaligned;
  assign exc_int  = !bus.stall && bus.irq && bus.irq_en && (state_q == StRun) && !exc_adel;

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    code_d  = code_q;
    state_d = state_q;
    taken_d = 1'b0;

    if (!bus.stall) begin
      if (exc_adel) begin
        pc_d    = EXC_VECTOR;
        code_d  = EXC_ADEL;
        state_d = StHandler;
        taken_d = 1'b1;
        // A nested fault must not clobber the original return address
        if (state_q == StRun) begin
          epc_d = pc_q;
        end
      end else if (exc_int) begin
        pc_d    = EXC_VECTOR;
        // Resume at the instruction that would have been fetched next
        epc_d   = npc;
        code_d  = EXC_INT;
        state_d = StHandler;
        taken_d = 1'b1;
      end else begin
        pc_d = npc;
        if (bus.sel == SEL_ERET) begin
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      code_q  <= EXC_INT;
      taken_q <= 1'b0;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
      taken_q <= taken_d;
      state_q <= state_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.epc       = epc_q;
  assign bus.exl       = (state_q == StHandler);
  assign bus.exc_code  = code_q;
  assign bus.exc_taken = taken_q;

endmodule
